// File: rtl/pixel_pattern_writer.sv
// -----------------------------------------------------------------------------
// pixel_pattern_writer
//
// Bus-master FSM that brings up the memory-mapped display and fills it:
//   1. poll the status register until bit1 is set, then until bit0 is set,
//   2. write PIX_COUNT pixel words starting at BASE_ADDR+PIX_OFS,
//   3. write CTRL_VAL to the control register, then report done.
// The fill pattern (solid / incrementing / checker) is latched at start.
//
// Optional feature macro: PIXGEN_POLL_TIMEOUT_EN
//   Defined   -> polling is bounded by TIMEOUT cycles; expiry ends the run in
//                DONE with o_error=1 and no writes issued.
//   Undefined -> polling waits forever, o_error is tied low.
//
// Ports
//   i_clock      clock, all state on rising edge
//   i_reset      synchronous active-high reset
//   i_start      begin a sequence (sampled in IDLE and DONE only)
//   i_mode[1:0]  0 solid, 1 incrementing, 2 checker, 3 solid
//   o_mem_addr   bus address
//   o_mem_wdata  bus write data
//   o_mem_we     write request
//   o_mem_re     read request
//   i_mem_rdata  read data, valid when i_mem_ready && o_mem_re
//   i_mem_ready  completes the current request on this edge
//   o_busy       high in every state except IDLE/DONE
//   o_done       high in DONE until the next accepted start
//   o_error      poll timeout flag
// -----------------------------------------------------------------------------
module pixel_pattern_writer #(
   parameter int unsigned       DATA_W     = 64,
   parameter int unsigned       ADDR_W     = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h0200_0000_0000_0000,
   parameter int unsigned       STATUS_OFS = 2,
   parameter int unsigned       CTRL_OFS   = 0,
   parameter int unsigned       PIX_OFS    = 604,
   parameter int unsigned       PIX_COUNT  = 600,
   parameter logic [DATA_W-1:0] CTRL_VAL   = 64'd5,
   parameter logic [DATA_W-1:0] COLOR      = 64'hC030_0CF0_3CCC_54FC,
   parameter int unsigned       TIMEOUT    = 1024
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_we,
   output logic              o_mem_re,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   // Index must be able to hold PIX_COUNT (the value after the last pixel).
   localparam int unsigned       IDX_W       = (PIX_COUNT > 0) ? $clog2(PIX_COUNT + 1) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'((PIX_COUNT > 0) ? PIX_COUNT - 1 : 0);
   localparam logic [ADDR_W-1:0] STATUS_ADDR = BASE_ADDR + ADDR_W'(STATUS_OFS);
   localparam logic [ADDR_W-1:0] CTRL_ADDR   = BASE_ADDR + ADDR_W'(CTRL_OFS);
   localparam logic [ADDR_W-1:0] PIX_BASE    = BASE_ADDR + ADDR_W'(PIX_OFS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POLL1 = 3'd1,
      S_POLL0 = 3'd2,
      S_FILL  = 3'd3,
      S_CTRL  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [1:0] M_INCR    = 2'd1;
   localparam logic [1:0] M_CHECKER = 2'd2;

   state_t            r_state;
   state_t            w_next;
   logic [IDX_W-1:0]  r_index;
   logic [1:0]        r_mode;
   logic              w_start_ok;
   logic              w_polling;
   logic              w_timeout;
   logic [DATA_W-1:0] w_pix;
   logic [ADDR_W-1:0] w_pix_addr;

   // Only the two status bits are inspected; TIMEOUT is folded in so the
   // default build does not carry a dangling parameter.
   logic w_unused_bits;
   assign w_unused_bits = ^{i_mem_rdata[DATA_W-1:2], (TIMEOUT != 0)};

   // A start is honoured only when not busy; DONE behaves like IDLE here.
   assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_polling  = (r_state == S_POLL1) || (r_state == S_POLL0);

   // --------------------------------------------------------------------------
   // Optional poll timeout
   // --------------------------------------------------------------------------
`ifdef PIXGEN_POLL_TIMEOUT_EN
   localparam int unsigned      TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_error;

   // Counter covers POLL1 and POLL0 together; POLL1 is only ever entered
   // through an accepted start, so that is where it clears.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_tmo_cnt <= '0;
      end else if (w_start_ok) begin
         r_tmo_cnt <= '0;
      end else if (w_polling) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // Expires on the TIMEOUT-th poll cycle.
   assign w_timeout = w_polling && (r_tmo_cnt == TMO_LAST);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_error <= 1'b0;
      end else if (w_start_ok) begin
         r_error <= 1'b0;
      end else if (w_polling && (w_next == S_DONE)) begin
         r_error <= 1'b1;
      end
   end

   assign o_error = r_error;
`else
   assign w_timeout = 1'b0;
   assign o_error   = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state
   // --------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next = S_POLL1;
         end
         S_POLL1: begin
            // A successful read wins over an expiring timeout.
            if (i_mem_ready && i_mem_rdata[1]) w_next = S_POLL0;
            else if (w_timeout)                 w_next = S_DONE;
         end
         S_POLL0: begin
            if (i_mem_ready && i_mem_rdata[0]) w_next = (PIX_COUNT == 0) ? S_CTRL : S_FILL;
            else if (w_timeout)                 w_next = S_DONE;
         end
         S_FILL: begin
            if (i_mem_ready && (r_index == LAST_IDX)) w_next = S_CTRL;
         end
         S_CTRL: begin
            if (i_mem_ready) w_next = S_DONE;
         end
         S_DONE: begin
            if (w_start_ok) w_next = S_POLL1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath registers: latched mode and pixel index
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_mode <= 2'd0;
      end else if (w_start_ok) begin
         r_mode <= i_mode;
      end
   end

   // Index is held at 0 through POLL0 so FILL always begins at pixel 0.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_index <= '0;
      end else if (w_start_ok || (r_state == S_POLL0)) begin
         r_index <= '0;
      end else if ((r_state == S_FILL) && i_mem_ready) begin
         r_index <= r_index + 1'b1;
      end
   end

   // Pattern generator: mode 3 falls through to solid.
   always_comb begin
      w_pix = COLOR;
      case (r_mode)
         M_INCR:    w_pix = COLOR + DATA_W'(r_index);
         M_CHECKER: w_pix = r_index[0] ? ~COLOR : COLOR;
         default:   w_pix = COLOR;
      endcase
   end

   assign w_pix_addr = PIX_BASE + ADDR_W'(r_index);

   // --------------------------------------------------------------------------
   // FSM: outputs
   // Outputs depend only on registered state, so a pending request stays
   // stable until the edge on which i_mem_ready completes it, and a reset
   // drops it on that same edge.
   // --------------------------------------------------------------------------
   always_comb begin
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_we    = 1'b0;
      o_mem_re    = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_POLL1, S_POLL0: begin
            o_mem_re   = 1'b1;
            o_mem_addr = STATUS_ADDR;
            o_busy     = 1'b1;
         end
         S_FILL: begin
            o_mem_we    = 1'b1;
            o_mem_addr  = w_pix_addr;
            o_mem_wdata = w_pix;
            o_busy      = 1'b1;
         end
         S_CTRL: begin
            o_mem_we    = 1'b1;
            o_mem_addr  = CTRL_ADDR;
            o_mem_wdata = CTRL_VAL;
            o_busy      = 1'b1;
         end
         S_DONE: begin
            o_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
